// File: rtl/buffered_simplex_xbar.sv
// rtl/buffered_simplex_xbar.sv - NumIn x NumOut simplex crossbar with per-output RR arbiter, grant lock and FIFO
module buffered_simplex_xbar #(
    parameter int unsigned NumIn        = 4,
    parameter int unsigned NumOut       = 5,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned OutFifoDepth = 2,
    parameter bit          LockGrant    = 1'b1,
    localparam int unsigned NumInLog    = (NumIn == 1) ? 1 : $clog2(NumIn),
    localparam int unsigned NumOutLog   = (NumOut == 1) ? 1 : $clog2(NumOut),
    localparam int unsigned CntWidth    = (OutFifoDepth == 0) ? 1 : $clog2(OutFifoDepth + 1)
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NumIn-1:0]                    valid_i,
    output logic [NumIn-1:0]                    ready_o,
    input  logic [NumIn-1:0][NumOutLog-1:0]     tgt_addr_i,
    input  logic [NumIn-1:0]                    last_i,
    input  logic [NumIn-1:0][DataWidth-1:0]     data_i,
    output logic [NumIn-1:0]                    addr_err_o,
    output logic [NumOut-1:0]                   valid_o,
    input  logic [NumOut-1:0]                   ready_i,
    output logic [NumOut-1:0][NumInLog-1:0]     ini_addr_o,
    output logic [NumOut-1:0]                   last_o,
    output logic [NumOut-1:0][DataWidth-1:0]    data_o,
    output logic [NumOut-1:0][CntWidth-1:0]     fill_o
);

    if (NumIn == 0) begin : g_err_num_in
        $fatal(1, "buffered_simplex_xbar: NumIn must be >= 1");
    end
    if (NumOut == 0) begin : g_err_num_out
        $fatal(1, "buffered_simplex_xbar: NumOut must be >= 1");
    end
    if (NumOut > (1 << NumOutLog)) begin : g_err_addr_width
        $fatal(1, "buffered_simplex_xbar: tgt_addr_i too narrow for NumOut");
    end

    typedef enum logic {LOCK_IDLE, LOCK_HELD} lock_state_e;

    lock_state_e                      lock_q [NumOut];
    lock_state_e                      lock_d [NumOut];
    logic [NumInLog-1:0]              owner_q [NumOut];
    logic [NumInLog-1:0]              owner_d [NumOut];
    logic [NumInLog-1:0]              ptr_q [NumOut];
    logic [NumInLog-1:0]              ptr_d [NumOut];
    logic [NumInLog-1:0]              winner [NumOut];
    logic [NumOut-1:0]                req_any;
    logic [NumOut-1:0]                sink_rdy;
    logic [NumOut-1:0]                xfer_in;
    logic [NumOut-1:0]                win_last;
    logic [NumOut-1:0][DataWidth-1:0] win_data;
    logic [NumOut-1:0][NumIn-1:0]     grant;
    logic [NumIn-1:0]                 in_range;

    always_comb begin
        for (int j = 0; j < NumIn; j++) begin
            in_range[j] = (32'(tgt_addr_i[j]) < NumOut);
        end
    end

    // Cyclic scan from the RR pointer; a held lock narrows candidates to the owner.
    always_comb begin
        int   idx;
        logic held;
        idx  = 0;
        held = 1'b0;
        for (int k = 0; k < NumOut; k++) begin
            req_any[k] = 1'b0;
            winner[k]  = '0;
            held       = LockGrant && (lock_q[k] == LOCK_HELD);
            for (int off = 0; off < NumIn; off++) begin
                idx = int'(ptr_q[k]) + off;
                if (idx >= int'(NumIn)) begin
                    idx = idx - int'(NumIn);
                end
                if (!req_any[k] && valid_i[idx] && in_range[idx] &&
                    (tgt_addr_i[idx] == NumOutLog'(k)) &&
                    (!held || (owner_q[k] == NumInLog'(idx)))) begin
                    req_any[k] = 1'b1;
                    winner[k]  = NumInLog'(idx);
                end
            end
            xfer_in[k]  = req_any[k] && sink_rdy[k];
            win_last[k] = last_i[winner[k]];
            win_data[k] = data_i[winner[k]];
            for (int j = 0; j < NumIn; j++) begin
                grant[k][j] = xfer_in[k] && (winner[k] == NumInLog'(j));
            end
        end
    end

    always_comb begin
        for (int j = 0; j < NumIn; j++) begin
            addr_err_o[j] = valid_i[j] && !in_range[j];
            ready_o[j]    = addr_err_o[j];
            for (int k = 0; k < NumOut; k++) begin
                ready_o[j] = ready_o[j] | grant[k][j];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NumOut; k++) begin
            lock_d[k]  = lock_q[k];
            owner_d[k] = owner_q[k];
            ptr_d[k]   = ptr_q[k];
            if (xfer_in[k]) begin
                ptr_d[k] = (winner[k] == NumInLog'(NumIn - 1)) ? '0 : winner[k] + 1'b1;
                if (LockGrant) begin
                    case (lock_q[k])
                        LOCK_IDLE: begin
                            if (!win_last[k]) begin
                                lock_d[k]  = LOCK_HELD;
                                owner_d[k] = winner[k];
                            end
                        end
                        LOCK_HELD: begin
                            if (win_last[k]) begin
                                lock_d[k] = LOCK_IDLE;
                            end
                        end
                        default: lock_d[k] = LOCK_IDLE;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NumOut; k++) begin
                lock_q[k]  <= LOCK_IDLE;
                owner_q[k] <= '0;
                ptr_q[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < NumOut; k++) begin
                lock_q[k]  <= lock_d[k];
                owner_q[k] <= owner_d[k];
                ptr_q[k]   <= ptr_d[k];
            end
        end
    end

    if (OutFifoDepth > 0) begin : g_fifo
        localparam int unsigned PtrW = (OutFifoDepth > 1) ? $clog2(OutFifoDepth) : 1;

        for (genvar k = 0; k < NumOut; k++) begin : g_out
            logic [DataWidth-1:0] mem_data [OutFifoDepth];
            logic [NumInLog-1:0]  mem_ini  [OutFifoDepth];
            logic [OutFifoDepth-1:0] mem_last;
            logic [PtrW-1:0]      wptr_q;
            logic [PtrW-1:0]      rptr_q;
            logic [CntWidth-1:0]  fill_q;
            logic                 pop;

            // No pop-through: a full FIFO refuses pushes even while draining.
            assign sink_rdy[k] = (fill_q < CntWidth'(OutFifoDepth));
            assign pop         = (fill_q != '0) && ready_i[k];

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    for (int e = 0; e < OutFifoDepth; e++) begin
                        mem_data[e] <= '0;
                        mem_ini[e]  <= '0;
                    end
                    mem_last <= '0;
                    wptr_q   <= '0;
                    rptr_q   <= '0;
                    fill_q   <= '0;
                end else begin
                    if (xfer_in[k]) begin
                        mem_data[wptr_q] <= win_data[k];
                        mem_ini[wptr_q]  <= winner[k];
                        mem_last[wptr_q] <= win_last[k];
                        wptr_q <= (wptr_q == PtrW'(OutFifoDepth - 1)) ? '0 : wptr_q + 1'b1;
                    end
                    if (pop) begin
                        rptr_q <= (rptr_q == PtrW'(OutFifoDepth - 1)) ? '0 : rptr_q + 1'b1;
                    end
                    if (xfer_in[k] && !pop) begin
                        fill_q <= fill_q + 1'b1;
                    end else if (!xfer_in[k] && pop) begin
                        fill_q <= fill_q - 1'b1;
                    end
                end
            end

            assign valid_o[k]    = (fill_q != '0);
            assign data_o[k]     = mem_data[rptr_q];
            assign ini_addr_o[k] = mem_ini[rptr_q];
            assign last_o[k]     = mem_last[rptr_q];
            assign fill_o[k]     = fill_q;
        end
    end else begin : g_bypass
        for (genvar k = 0; k < NumOut; k++) begin : g_out
            assign sink_rdy[k]   = ready_i[k];
            assign valid_o[k]    = req_any[k];
            assign data_o[k]     = req_any[k] ? win_data[k] : '0;
            assign ini_addr_o[k] = req_any[k] ? winner[k] : '0;
            assign last_o[k]     = req_any[k] && win_last[k];
            assign fill_o[k]     = '0;
        end
    end

endmodule

// File: doc/buffered_simplex_xbar.md
Name: buffered_simplex_xbar

Overview:
- Next-generation uni-directional NumIn x NumOut crossbar for cluster interconnects.
- Each output has a built-in round-robin arbiter, an optional multi-beat grant lock driven by a per-beat last flag, and a parametrised output FIFO.
- Inputs addressing a target that does not exist are absorbed and flagged.
- Sits between initiator request ports and bank/target ports, like the existing simplex crossbars, but decouples target back-pressure with real buffering.

Parameters:
- NumIn, 4, number of initiators (>=1).
- NumOut, 5, number of targets (>=1; need not be a power of two).
- DataWidth, 32, payload width.
- OutFifoDepth, 2, per-output FIFO entries; 0 = combinational bypass.
- LockGrant, 1'b1, 1 = hold the output grant on the winning initiator until its last beat.
- NumInLog (localparam), NumIn==1 ? 1 : $clog2(NumIn).
- NumOutLog (localparam), NumOut==1 ? 1 : $clog2(NumOut).
- CntWidth (localparam), $clog2(OutFifoDepth+1), minimum 1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- valid_i  in  NumIn  initiator beat valid
- ready_o  out  NumIn  initiator beat accepted
- tgt_addr_i  in  NumIn x NumOutLog  target index
- last_i  in  NumIn  final beat of a transaction
- data_i  in  NumIn x DataWidth  payload
- addr_err_o  out  NumIn  pulse: beat to an out-of-range target was discarded
- valid_o  out  NumOut  target beat valid
- ready_i  in  NumOut  target ready
- ini_addr_o  out  NumOut x NumInLog  source initiator of the beat
- last_o  out  NumOut  forwarded last flag
- data_o  out  NumOut x DataWidth  payload
- fill_o  out  NumOut x CntWidth  FIFO occupancy (0 when OutFifoDepth=0)

Behaviour:
- Reset (async assert): all FIFOs empty; valid_o=0, ini_addr_o=0, last_o=0, data_o=0 (FIFO mode), fill_o=0, RR pointers=0, lock FSMs IDLE, addr_err_o=0.
- Handshake:
  - A beat transfers when valid_i&ready_o (input side) or valid_o&ready_i (output side).
  - Initiators keep valid, addr, data and last stable until ready.
  - ready_o may depend combinationally on valid_i.
- Out-of-range address (tgt_addr_i>=NumOut):
  - ready_o=1 in the same cycle.
  - addr_err_o=1 that cycle.
  - The beat is dropped; no output is affected.
- Per-output sink readiness:
  - FIFO mode: sink_rdy = (fill<OutFifoDepth). There is no pop-through when full, so a full FIFO blocks even if ready_i=1 that cycle.
  - Bypass mode: sink_rdy = ready_i.
- RR arbitration per output k:
  - Candidates are inputs j with valid_i[j] and tgt_addr_i[j]==k.
  - The winner is the first candidate at or after ptr[k], cyclically.
  - ready_o[winner] = sink_rdy.
  - On transfer: ptr[k] <= winner+1, wrapping NumIn-1 -> 0. The pointer does not move without a transfer.
- Lock FSM per output (only when LockGrant=1):
  - IDLE -> LOCKED(owner=winner) on a transfer with last_i=0.
  - LOCKED: only the owner is eligible; other candidates see ready_o=0.
  - LOCKED -> IDLE on the owner's transfer with last_i=1.
  - A single-beat transfer (last_i=1) in IDLE stays in IDLE.
  - When LockGrant=0, last_i is only forwarded and no locking happens.
- FIFO mode:
  - Push on input transfer; pop on valid_o&ready_i.
  - Push and pop in the same cycle leaves fill unchanged.
  - valid_o = fill!=0.
  - Outputs come from the head entry; latency from input accept to valid_o is 1 cycle.
  - Read/write pointers wrap at OutFifoDepth-1 -> 0. OutFifoDepth need not be a power of two.
- Bypass mode:
  - valid_o = winner valid, combinational.
  - data_o, ini_addr_o and last_o are muxed from the winner; 0 latency.
- Each input targets at most one output per cycle, so ready_o is a pure OR over outputs.
- NumIn==1: arbitration is degenerate and ptr stays 0.
- Elaboration $fatal if NumIn==0, NumOut==0, or NumOutLog exceeds what tgt_addr_i can carry.

Test Plan:
- Reset then idle: fill_o=0, valid_o=0. Assert rst_ni low mid-burst with fill=2 -> everything clears immediately, lock returns to IDLE.
- NumIn=4, all inputs send single beats (last=1) to target 2, ready_i[2]=1, depth 2 -> grant order 0,1,2,3,0. ini_addr_o shows 0,1,2,3 one cycle later. fill_o[2] never exceeds 1.
- LockGrant=1: input 1 sends a 3-beat burst (last on 3rd) to target 0 while input 0 is also requesting -> all 3 beats from input 1 are consecutive. Input 0 is granted on the 4th cycle.
- Back-pressure: ready_i[3]=0 with depth 2 -> 2 beats accepted, fill_o=2, ready_o=0 afterwards. Raise ready_i for 1 cycle -> fill 2->1 and a new push lands the following cycle.
- Out-of-range: NumOut=5, input 2 addr=6 -> ready_o[2]=1 and addr_err_o[2]=1 for 1 cycle; no valid_o asserted anywhere.
- OutFifoDepth=0: input 3 -> target 1 with ready_i=1 -> valid_o[1] in the same cycle, data_o=data_i[3], ini_addr_o=3.
